// File: rtl/video_timing_gen.sv
// Raster timing generator for the LVDS transmitter: produces registered hsync/vsync/de,
// pixel coordinates, a frame-start strobe and built-in RGB test patterns.
module video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic [3:0]  fsm_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int SUB_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0] H_FP_END   = H_W'(H_ACTIVE + H_FP - 1);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] V_FP_END   = V_W'(V_ACTIVE + V_FP - 1);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } axis_state_t;

    axis_state_t      h_state, v_state;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic [7:0]       frame_cnt;
    logic [1:0]       pattern_q;
    logic [2:0]       bar_idx;
    logic [SUB_W-1:0] bar_sub;
    logic             bar_over;

    logic        h_wrap, v_last, pix_active, frame_first;
    logic [10:0] h_cnt11, v_cnt11;
    logic [1:0]  cur_pat;
    logic [7:0]  ramp;
    logic [23:0] bar_rgb, pix_rgb;

    assign fsm_state   = {h_state, v_state};
    assign h_wrap      = (h_cnt == H_LAST);
    assign v_last      = (v_cnt == V_LAST);
    assign pix_active  = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    assign h_cnt11     = 11'(h_cnt);
    assign v_cnt11     = 11'(v_cnt);

    // The pattern for pixel (0,0) comes straight from the input; the rest of the frame uses the latched copy.
    assign cur_pat = frame_first ? pattern : pattern_q;
    assign ramp    = h_cnt11[7:0] + frame_cnt;

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
        if (bar_over) begin
            bar_rgb = 24'h000000;
        end
    end

    always_comb begin
        pix_rgb = 24'h000000;
        case (cur_pat)
            2'd0: pix_rgb = bar_rgb;
            2'd1: pix_rgb = {ramp, ramp, ramp};
            2'd2: pix_rgb = (h_cnt11[5] ^ v_cnt11[5]) ? WHITE : 24'h000000;
            default: pix_rgb = WHITE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_state     <= ST_ACTIVE;
            v_state     <= ST_ACTIVE;
            bar_idx     <= '0;
            bar_sub     <= '0;
            bar_over    <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            // Idle keeps frame_cnt so the ramp continues after a pause; only reset clears it.
            if (rst) begin
                frame_cnt <= '0;
                pattern_q <= '0;
            end
        end else begin
            de                  <= pix_active;
            hsync               <= (h_state == ST_SYNC) ? HS_POL : ~HS_POL;
            vsync               <= (v_state == ST_SYNC) ? VS_POL : ~VS_POL;
            {red, green, blue}  <= pix_active ? pix_rgb : 24'h000000;
            x                   <= pix_active ? h_cnt11 : 11'd0;
            y                   <= pix_active ? v_cnt11 : 11'd0;
            frame_start         <= frame_first;
            if (frame_first) begin
                pattern_q <= pattern;
            end

            h_cnt <= h_wrap ? '0 : h_cnt + H_W'(1);
            if (h_wrap) begin
                v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
                if (v_last) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end

            case (h_state)
                ST_ACTIVE: if (h_cnt == H_ACT_END)  h_state <= ST_FP;
                ST_FP:     if (h_cnt == H_FP_END)   h_state <= ST_SYNC;
                ST_SYNC:   if (h_cnt == H_SYNC_END) h_state <= ST_BP;
                ST_BP:     if (h_wrap)              h_state <= ST_ACTIVE;
                default:                            h_state <= ST_ACTIVE;
            endcase

            if (h_wrap) begin
                case (v_state)
                    ST_ACTIVE: if (v_cnt == V_ACT_END)  v_state <= ST_FP;
                    ST_FP:     if (v_cnt == V_FP_END)   v_state <= ST_SYNC;
                    ST_SYNC:   if (v_cnt == V_SYNC_END) v_state <= ST_BP;
                    ST_BP:     if (v_last)              v_state <= ST_ACTIVE;
                    default:                            v_state <= ST_ACTIVE;
                endcase
            end

            // Bar index steps every BAR_W active pixels; bar_over blacks out any remainder.
            if (h_wrap) begin
                bar_idx  <= '0;
                bar_sub  <= '0;
                bar_over <= 1'b0;
            end else if (h_state == ST_ACTIVE) begin
                if (bar_sub == SUB_LAST) begin
                    bar_sub <= '0;
                    bar_idx <= bar_idx + 3'd1;
                    if (bar_idx == 3'd7) begin
                        bar_over <= 1'b1;
                    end
                end else begin
                    bar_sub <= bar_sub + SUB_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: stimulus pushes expected output words
// from an arithmetic raster model; a monitor pops and compares after every clock edge.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam bit HS_POL = 1'b1, VS_POL = 1'b1;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  red, green, blue;
    logic [10:0] x, y;
    logic [3:0]  fsm_state;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .x(x), .y(y), .frame_start(frame_start), .fsm_state(fsm_state)
    );

    // scoreboard state
    logic [49:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;
    int n_print  = 0;
    bit running  = 1'b0;

    // reference model state: position within the frame, frames completed, latched pattern
    int         m_pos  = 0;
    int         m_fcnt = 0;
    logic [1:0] m_pat  = 2'd0;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [49:0] pack(input logic fs, input logic d, input logic hs,
                                         input logic vs, input logic [23:0] rgb,
                                         input logic [10:0] px, input logic [10:0] py);
        return {fs, d, hs, vs, rgb, px, py};
    endfunction

    function automatic logic [49:0] model_step(input logic r, input logic e, input logic [1:0] p);
        int h, v, b;
        logic d, hs, vs;
        logic [23:0] rgb;
        logic [7:0] g;
        if (r || !e) begin
            m_pos = 0;
            if (r) m_fcnt = 0;
            return pack(1'b0, 1'b0, !HS_POL, !VS_POL, 24'h0, 11'd0, 11'd0);
        end
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) m_pat = p;
        d  = (h < H_ACTIVE) && (v < V_ACTIVE);
        hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
        vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
        case (m_pat)
            2'd0: begin
                b = h / BAR_W;
                rgb = (b < 8) ? bar_tab[b] : 24'h0;
            end
            2'd1: begin
                g = 8'((h + m_fcnt) % 256);
                rgb = {g, g, g};
            end
            2'd2: rgb = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            default: rgb = 24'hFFFFFF;
        endcase
        if (!d) rgb = 24'h0;
        model_step = pack(m_pos == 0, d, hs, vs, rgb, d ? 11'(h) : 11'd0, d ? 11'(v) : 11'd0);
        m_pos = m_pos + 1;
        if (m_pos == HT * VT) begin
            m_pos  = 0;
            m_fcnt = (m_fcnt + 1) % 256;
        end
    endfunction

    // driver: apply inputs for the coming edge and push the expected response
    task automatic step(input logic r, input logic e, input logic [1:0] p);
        @(negedge clk);
        rst = r;
        enable = e;
        pattern = p;
        exp_q.push_back(model_step(r, e, p));
        running = 1'b1;
        n_cycle++;
    endtask

    // monitor: one comparison per edge once stimulus is flowing
    logic [49:0] mon_exp, mon_act;
    always @(posedge clk) begin
        #1;
        if (running) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow: no expected word queued at time %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = pack(frame_start, de, hsync, vsync, {red, green, blue}, x, y);
                if (mon_act === mon_exp) begin
                    n_pass++;
                end else if (n_print < 40) begin
                    n_print++;
                    $display("FAIL raster t=%0t act{fs,de,hs,vs,rgb,x,y}=%h exp=%h",
                             $time, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    logic [1:0] rp;
    initial begin
        repeat (3) step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd0);                    // reset wins over enable

        repeat (2 * HT * VT) step(1'b0, 1'b1, 2'd0); // colour bars, two frames

        repeat (40) step(1'b0, 1'b1, 2'd0);         // switch to solid white mid-frame
        repeat (HT * VT - 40) step(1'b0, 1'b1, 2'd3);
        repeat (HT * VT) step(1'b0, 1'b1, 2'd3);

        rp = 2'($urandom_range(0, 3));              // drop enable at line 2, clock 7
        repeat (2 * HT + 7) step(1'b0, 1'b1, rp);
        repeat (5) step(1'b0, 1'b0, rp);
        repeat (200) step(1'b0, 1'b1, 2'd2);

        repeat (70) step(1'b0, 1'b1, 2'd1);         // reset mid-frame with enable high
        step(1'b1, 1'b1, 2'd1);
        repeat (300) step(1'b0, 1'b1, 2'd1);

        rp = 2'd0;                                   // randomized mix
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) rp = 2'($urandom_range(0, 3));
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) != 0, rp);
        end

        step(1'b1, 1'b0, 2'd1);                     // ramp long enough to wrap frame_cnt
        repeat (258 * HT * VT) step(1'b0, 1'b1, 2'd1);

        @(negedge clk);
        running = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected words left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
